// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: shared state encodings and default timing constants for the USB FIFO responder.
package usb_fifo_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_DRIVE, RX_PRECH} rx_state_t;
  typedef enum logic {TX_IDLE, TX_PRECH} tx_state_t;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_RD_ACCESS = 3;
  localparam int DEF_PRECHARGE = 4;
endpackage

// File: rtl/usb_byte_fifo.sv
// usb_byte_fifo: synchronous byte FIFO with occupancy count, full/empty flags and a combinational head.
module usb_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge CLK)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/usb_fifo_responder.sv
// usb_fifo_responder: FT245-style device-side bus emulator bridging async RD/WR strobes to host FIFOs.
module usb_fifo_responder
  import usb_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int RD_ACCESS = DEF_RD_ACCESS,
  parameter int PRECHARGE = DEF_PRECHARGE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] USBX_IN,
  output logic [7:0] USBX_OUT,
  output logic       USBX_OE,
  output logic       RXF,
  output logic       TXE,
  input  logic [7:0] HOST_RX_DATA,
  input  logic       HOST_RX_VALID,
  output logic       HOST_RX_READY,
  output logic [7:0] HOST_TX_DATA,
  output logic       HOST_TX_VALID,
  input  logic       HOST_TX_READY,
  output logic       OVERRUN,
  output logic       UNDERRUN
);
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [7:0] rx_cnt, rx_cnt_next, tx_cnt, tx_cnt_next, in1, in2, rx_head;
  logic [2:0] rd_sync, wr_sync;
  logic rd_fall, rd_rise, wr_fall, rx_pop, tx_push, rx_under, rx_full, rx_empty, tx_full, tx_empty;
  assign rd_fall = !rd_sync[1] && rd_sync[2];
  assign rd_rise = rd_sync[1] && !rd_sync[2];
  assign wr_fall = !wr_sync[1] && wr_sync[2];
  assign tx_push = wr_fall && !TXE;
  assign HOST_RX_READY = !rx_full;
  assign HOST_TX_VALID = !tx_empty;

  usb_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .CLK(CLK), .RST(RST), .push(HOST_RX_VALID && HOST_RX_READY), .pop(rx_pop),
    .wdata(HOST_RX_DATA), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );
  usb_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .CLK(CLK), .RST(RST), .push(tx_push), .pop(HOST_TX_VALID && HOST_TX_READY),
    .wdata(in2), .rdata(HOST_TX_DATA), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    rx_next = rx_state;
    rx_cnt_next = rx_cnt;
    rx_pop = 1'b0;
    case (rx_state)
      RX_IDLE: if (rd_fall) begin
        rx_next = RX_WAIT;
        rx_cnt_next = 8'(RD_ACCESS);
      end
      RX_WAIT, RX_DRIVE: if (rd_rise) begin
        rx_next = RX_PRECH;
        rx_cnt_next = 8'(PRECHARGE - 1);
        rx_pop = !rx_under;
      end else if (rx_state == RX_WAIT) begin
        rx_next = rx_cnt == '0 ? RX_DRIVE : RX_WAIT;
        rx_cnt_next = rx_cnt == '0 ? rx_cnt : rx_cnt - 8'd1;
      end
      RX_PRECH: begin
        rx_next = rx_cnt == '0 ? RX_IDLE : RX_PRECH;
        rx_cnt_next = rx_cnt == '0 ? rx_cnt : rx_cnt - 8'd1;
      end
    endcase
  end

  always_comb begin
    tx_next = tx_state;
    tx_cnt_next = tx_cnt;
    if (tx_state == TX_IDLE) begin
      tx_next = tx_push ? TX_PRECH : TX_IDLE;
      tx_cnt_next = tx_push ? 8'(PRECHARGE - 1) : tx_cnt;
    end else begin
      tx_next = tx_cnt == '0 ? TX_IDLE : TX_PRECH;
      tx_cnt_next = tx_cnt == '0 ? tx_cnt : tx_cnt - 8'd1;
    end
  end

  // Flags are precomputed so a strobe detected this cycle already raises RXF/TXE.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rd_sync <= '1;
      wr_sync <= '1;
      in1 <= '0;
      in2 <= '0;
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
      rx_cnt <= '0;
      tx_cnt <= '0;
      rx_under <= 1'b0;
      USBX_OUT <= '0;
      USBX_OE <= 1'b0;
      RXF <= 1'b1;
      TXE <= 1'b1;
      OVERRUN <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      rd_sync <= {rd_sync[1:0], RD};
      wr_sync <= {wr_sync[1:0], WR};
      in1 <= USBX_IN;
      in2 <= in1;
      rx_state <= rx_next;
      tx_state <= tx_next;
      rx_cnt <= rx_cnt_next;
      tx_cnt <= tx_cnt_next;
      USBX_OE <= rx_next == RX_DRIVE;
      RXF <= !(rx_state == RX_IDLE && !rx_empty && !rd_fall);
      TXE <= !(tx_state == TX_IDLE && !tx_full && !wr_fall);
      if (rx_state == RX_IDLE && rd_fall) begin
        USBX_OUT <= rx_empty ? 8'h00 : rx_head;
        rx_under <= rx_empty;
      end
      if (rd_fall && (rx_state != RX_IDLE || rx_empty)) UNDERRUN <= 1'b1;
      if (wr_fall && TXE) OVERRUN <= 1'b1;
    end
endmodule

// File: tb/tb_usb_fifo_responder.sv
// tb_usb_fifo_responder: directed bench for the USB FIFO responder with default parameters.
module tb_usb_fifo_responder;
  logic CLK = 1'b0, RST, RD, WR, USBX_OE, RXF, TXE, HOST_RX_VALID, HOST_RX_READY;
  logic HOST_TX_VALID, HOST_TX_READY, OVERRUN, UNDERRUN;
  logic [7:0] USBX_IN, USBX_OUT, HOST_RX_DATA, HOST_TX_DATA, rd_byte;
  int checks = 0, errors = 0;

  usb_fifo_responder dut (
    .CLK(CLK), .RST(RST), .RD(RD), .WR(WR), .USBX_IN(USBX_IN), .USBX_OUT(USBX_OUT),
    .USBX_OE(USBX_OE), .RXF(RXF), .TXE(TXE), .HOST_RX_DATA(HOST_RX_DATA),
    .HOST_RX_VALID(HOST_RX_VALID), .HOST_RX_READY(HOST_RX_READY), .HOST_TX_DATA(HOST_TX_DATA),
    .HOST_TX_VALID(HOST_TX_VALID), .HOST_TX_READY(HOST_TX_READY), .OVERRUN(OVERRUN),
    .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] d);
    HOST_RX_DATA = d;
    HOST_RX_VALID = 1'b1;
    step(1);
    HOST_RX_VALID = 1'b0;
  endtask

  task automatic dev_write(input logic [7:0] d);
    USBX_IN = d;
    WR = 1'b0;
    step(5);
    WR = 1'b1;
    step(3);
  endtask

  // 80 ns RD pulse; byte captured while the bus is driven.
  task automatic dev_read(input string tag, input logic [7:0] exp);
    RD = 1'b0;
    step(7);
    chk({tag, "_oe"}, 8'(USBX_OE), 8'h01);
    chk(tag, USBX_OUT, exp);
    step(1);
    RD = 1'b1;
    step(8);
  endtask

  initial begin
    RST = 1'b1; RD = 1'b1; WR = 1'b1; USBX_IN = '0;
    HOST_RX_DATA = '0; HOST_RX_VALID = 1'b0; HOST_TX_READY = 1'b0;
    step(3);
    chk("rst_rxf", 8'(RXF), 8'h01);
    chk("rst_txe", 8'(TXE), 8'h01);
    chk("rst_oe", 8'(USBX_OE), 8'h00);
    chk("rst_out", USBX_OUT, 8'h00);
    chk("rst_ovr", 8'(OVERRUN), 8'h00);
    chk("rst_und", 8'(UNDERRUN), 8'h00);
    chk("rst_txv", 8'(HOST_TX_VALID), 8'h00);
    chk("rst_rxr", 8'(HOST_RX_READY), 8'h01);
    RST = 1'b0;
    step(1);
    chk("rel_txe", 8'(TXE), 8'h00);
    chk("rel_rxf", 8'(RXF), 8'h01);

    host_push(8'h07);
    step(1);
    chk("push_rxf", 8'(RXF), 8'h00);
    RD = 1'b0;
    step(6);
    chk("rd_oe_early", 8'(USBX_OE), 8'h00);
    chk("rd_rxf_busy", 8'(RXF), 8'h01);
    step(1);
    chk("rd_oe", 8'(USBX_OE), 8'h01);
    chk("rd_out", USBX_OUT, 8'h07);
    step(1);
    RD = 1'b1;
    step(2);
    chk("rd_oe_hold", 8'(USBX_OE), 8'h01);
    step(1);
    chk("rd_oe_off", 8'(USBX_OE), 8'h00);
    step(5);
    chk("rd_rxf_empty", 8'(RXF), 8'h01);
    chk("rd_und", 8'(UNDERRUN), 8'h00);

    dev_write(8'h21);
    dev_write(8'h61);
    chk("tx_valid", 8'(HOST_TX_VALID), 8'h01);
    chk("tx_d0", HOST_TX_DATA, 8'h21);
    HOST_TX_READY = 1'b1;
    step(1);
    chk("tx_d1", HOST_TX_DATA, 8'h61);
    step(1);
    HOST_TX_READY = 1'b0;
    chk("tx_empty", 8'(HOST_TX_VALID), 8'h00);
    chk("tx_ovr", 8'(OVERRUN), 8'h00);

    for (int i = 0; i < 15; i++) dev_write(8'h30 + 8'(i));
    chk("fill15_txe", 8'(TXE), 8'h00);
    dev_write(8'h3F);
    chk("fill16_txe", 8'(TXE), 8'h01);
    chk("fill16_ovr", 8'(OVERRUN), 8'h00);
    dev_write(8'hEE);
    chk("fill17_ovr", 8'(OVERRUN), 8'h01);
    chk("fill17_txe", 8'(TXE), 8'h01);
    HOST_TX_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), HOST_TX_DATA, 8'h30 + 8'(i));
      step(1);
    end
    HOST_TX_READY = 1'b0;
    chk("drain_valid", 8'(HOST_TX_VALID), 8'h00);
    chk("drain_txe", 8'(TXE), 8'h00);

    dev_read("und_out", 8'h00);
    chk("und_flag", 8'(UNDERRUN), 8'h01);
    chk("und_rxf", 8'(RXF), 8'h01);
    host_push(8'h5A);
    dev_read("und_noptr", 8'h5A);

    host_push(8'hA1);
    RD = 1'b0;
    step(7);
    chk("same_out", USBX_OUT, 8'hA1);
    step(1);
    RD = 1'b1;
    step(2);
    HOST_RX_DATA = 8'hA2;
    HOST_RX_VALID = 1'b1;
    step(1);
    HOST_RX_VALID = 1'b0;
    step(6);
    chk("same_rxf", 8'(RXF), 8'h00);
    dev_read("same_next", 8'hA2);
    chk("same_drained", 8'(RXF), 8'h01);

    for (int i = 0; i < 16; i++) host_push(8'h80 + 8'(i));
    chk("wrap_full", 8'(HOST_RX_READY), 8'h00);
    for (int i = 0; i < 4; i++) dev_read($sformatf("wrap_a%0d", i), 8'h80 + 8'(i));
    for (int i = 0; i < 4; i++) host_push(8'h90 + 8'(i));
    for (int i = 0; i < 16; i++)
      dev_read($sformatf("wrap_b%0d", i), i < 12 ? 8'h84 + 8'(i) : 8'h90 + 8'(i - 12));

    dev_write(8'h44);
    chk("mid_txv", 8'(HOST_TX_VALID), 8'h01);
    chk("mid_txe", 8'(TXE), 8'h00);
    host_push(8'h33);
    RD = 1'b0;
    step(7);
    chk("mid_oe", 8'(USBX_OE), 8'h01);
    RST = 1'b1;
    #1;
    chk("mid_rst_oe", 8'(USBX_OE), 8'h00);
    chk("mid_rst_rxf", 8'(RXF), 8'h01);
    chk("mid_rst_txe", 8'(TXE), 8'h01);
    chk("mid_rst_txv", 8'(HOST_TX_VALID), 8'h00);
    chk("mid_rst_out", USBX_OUT, 8'h00);
    RD = 1'b1;
    step(2);
    RST = 1'b0;
    step(1);
    chk("post_txe", 8'(TXE), 8'h00);
    chk("post_rxf", 8'(RXF), 8'h01);
    chk("post_und", 8'(UNDERRUN), 8'h00);
    chk("post_ovr", 8'(OVERRUN), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
